// File: rtl/mmcm_drp_reconfig_pkg.sv
// Shared constants for the MMCM DRP reconfiguration sequencer: register table,
// keep-masks, FSM encoding and the divider encoding record.
package mmcm_drp_reconfig_pkg;

    localparam int TBL_DEPTH = 5;
    localparam int IDX_W     = 3;

    localparam logic [6:0] ADDR_CLKOUT0_R1 = 7'h08;
    localparam logic [6:0] ADDR_CLKOUT0_R2 = 7'h09;
    localparam logic [6:0] ADDR_CLKFB_R1   = 7'h14;
    localparam logic [6:0] ADDR_CLKFB_R2   = 7'h15;
    localparam logic [6:0] ADDR_DIVCLK     = 7'h16;

    localparam logic [15:0] MASK_HILO   = 16'h1000;
    localparam logic [15:0] MASK_EDGE   = 16'hFC00;
    localparam logic [15:0] MASK_DIVCLK = 16'hC000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_ASSERT_RST,
        S_READ,
        S_WAIT_RD,
        S_WRITE,
        S_WAIT_WR,
        S_NEXT,
        S_RELEASE,
        S_WAIT_LOCK,
        S_DONE,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic [5:0] high;
        logic [5:0] low;
        logic       edg;
        logic       no_count;
    } div_enc_t;

    function automatic logic [6:0] tbl_addr(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    return ADDR_CLKOUT0_R1;
            3'd1:    return ADDR_CLKOUT0_R2;
            3'd2:    return ADDR_CLKFB_R1;
            3'd3:    return ADDR_CLKFB_R2;
            default: return ADDR_DIVCLK;
        endcase
    endfunction

    function automatic logic [15:0] tbl_mask(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0, 3'd2: return MASK_HILO;
            3'd1, 3'd3: return MASK_EDGE;
            default:    return MASK_DIVCLK;
        endcase
    endfunction

    // Dividers/multipliers are only representable in 1..127.
    function automatic logic div_valid(input logic [7:0] v);
        return (v != 8'd0) && !v[7];
    endfunction

endpackage

// File: rtl/mmcm_drp_reconfig_if.sv
// MMCM DRP bus: the sequencer is the master, the MMCM primitive the slave.
interface mmcm_drp_reconfig_if;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_daddr, drp_den, drp_dwe, drp_di,
        input  drp_do, drp_drdy
    );

    modport slave (
        input  drp_daddr, drp_den, drp_dwe, drp_di,
        output drp_do, drp_drdy
    );
endinterface

// File: rtl/mmcm_drp_reconfig_pll_timer_values.sv
// Splits a divide value into MMCM high/low counter times and the half-cycle edge bit.
module pll_timer_values (
    input  logic [6:0] divide,
    output logic [5:0] high,
    output logic [5:0] low,
    output logic       edg
);
    logic [5:0] half;

    assign half = divide[6:1];
    assign high = (half == 6'd0) ? 6'd1 : half;
    assign low  = half + {5'd0, divide[0]};
    assign edg  = (half == 6'd0) ? 1'b0 : divide[0];
endmodule

// File: rtl/mmcm_drp_reconfig.sv
// Runtime MMCM reconfiguration: holds the MMCM in reset, read-modify-writes the
// five divider registers over DRP, then releases reset and waits for lock.
module mmcm_drp_reconfig
    import mmcm_drp_reconfig_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 clkfb_mult,
    input  logic [7:0]                 clkout0_div,
    input  logic [7:0]                 divclk_div,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       mmcm_rst,
    input  logic                       mmcm_locked,
    mmcm_drp_reconfig_if.master        drp
);
    localparam int DRDY_CW = $clog2(DRDY_TIMEOUT + 1);
    localparam int LOCK_CW = $clog2(LOCK_TIMEOUT + 1);

    state_t             state;
    logic [7:0]         mult_q, div0_q, divclk_q;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [DRDY_CW-1:0] drdy_cnt;
    logic [LOCK_CW-1:0] lock_cnt;
    logic [15:0]        field;

    logic [5:0] o0_hi, o0_lo, fb_hi, fb_lo, dc_hi, dc_lo;
    logic       o0_e, fb_e, dc_e;
    div_enc_t   enc_o0, enc_fb, enc_dc;

    pll_timer_values u_clkout0 (.divide(div0_q[6:0]),   .high(o0_hi), .low(o0_lo), .edg(o0_e));
    pll_timer_values u_clkfb   (.divide(mult_q[6:0]),   .high(fb_hi), .low(fb_lo), .edg(fb_e));
    pll_timer_values u_divclk  (.divide(divclk_q[6:0]), .high(dc_hi), .low(dc_lo), .edg(dc_e));

    assign enc_o0 = '{high: o0_hi, low: o0_lo, edg: o0_e, no_count: (div0_q == 8'd1)};
    assign enc_fb = '{high: fb_hi, low: fb_lo, edg: fb_e, no_count: (mult_q == 8'd1)};
    assign enc_dc = '{high: dc_hi, low: dc_lo, edg: dc_e, no_count: (divclk_q == 8'd1)};

    assign idx_nxt = idx + 1'b1;

    always_comb begin
        field = 16'h0000;
        case (idx)
            3'd0:    field = {4'h0, enc_o0.high, enc_o0.low};
            3'd1:    field = {8'h00, enc_o0.edg, enc_o0.no_count, 6'h00};
            3'd2:    field = {4'h0, enc_fb.high, enc_fb.low};
            3'd3:    field = {8'h00, enc_fb.edg, enc_fb.no_count, 6'h00};
            default: field = {2'b00, enc_dc.edg, enc_dc.no_count, enc_dc.high, enc_dc.low};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            mmcm_rst      <= 1'b0;
            drp.drp_daddr <= 7'd0;
            drp.drp_den   <= 1'b0;
            drp.drp_dwe   <= 1'b0;
            drp.drp_di    <= 16'h0000;
            mult_q        <= 8'd0;
            div0_q        <= 8'd0;
            divclk_q      <= 8'd0;
            idx           <= '0;
            drdy_cnt      <= '0;
            lock_cnt      <= '0;
        end else begin
            done        <= 1'b0;
            drp.drp_den <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    mult_q   <= clkfb_mult;
                    div0_q   <= clkout0_div;
                    divclk_q <= divclk_div;
                    error    <= 1'b0;
                    busy     <= 1'b1;
                    state    <= S_CHECK;
                end
                S_CHECK: if (div_valid(mult_q) && div_valid(div0_q) && div_valid(divclk_q)) begin
                    mmcm_rst <= 1'b1;
                    idx      <= '0;
                    state    <= S_ASSERT_RST;
                end else begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_ERROR;
                end
                S_ASSERT_RST: begin
                    drp.drp_daddr <= tbl_addr(idx);
                    drp.drp_dwe   <= 1'b0;
                    drp.drp_den   <= 1'b1;
                    state         <= S_READ;
                end
                S_READ: begin
                    drdy_cnt <= '0;
                    state    <= S_WAIT_RD;
                end
                // drdy wins over a timeout landing in the same cycle.
                S_WAIT_RD: if (drp.drp_drdy) begin
                    drp.drp_di  <= (drp.drp_do & tbl_mask(idx)) | field;
                    drp.drp_dwe <= 1'b1;
                    drp.drp_den <= 1'b1;
                    state       <= S_WRITE;
                end else if (drdy_cnt == DRDY_CW'(DRDY_TIMEOUT - 1)) begin
                    error    <= 1'b1;
                    busy     <= 1'b0;
                    mmcm_rst <= 1'b0;
                    state    <= S_ERROR;
                end else begin
                    drdy_cnt <= drdy_cnt + 1'b1;
                end
                S_WRITE: begin
                    drp.drp_dwe <= 1'b0;
                    drdy_cnt    <= '0;
                    state       <= S_WAIT_WR;
                end
                S_WAIT_WR: if (drp.drp_drdy) begin
                    state <= S_NEXT;
                end else if (drdy_cnt == DRDY_CW'(DRDY_TIMEOUT - 1)) begin
                    error    <= 1'b1;
                    busy     <= 1'b0;
                    mmcm_rst <= 1'b0;
                    state    <= S_ERROR;
                end else begin
                    drdy_cnt <= drdy_cnt + 1'b1;
                end
                S_NEXT: if (idx == IDX_W'(TBL_DEPTH - 1)) begin
                    mmcm_rst <= 1'b0;
                    state    <= S_RELEASE;
                end else begin
                    idx           <= idx_nxt;
                    drp.drp_daddr <= tbl_addr(idx_nxt);
                    drp.drp_den   <= 1'b1;
                    state         <= S_READ;
                end
                S_RELEASE: begin
                    lock_cnt <= '0;
                    state    <= S_WAIT_LOCK;
                end
                S_WAIT_LOCK: if (mmcm_locked) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end else if (lock_cnt == LOCK_CW'(LOCK_TIMEOUT - 1)) begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_ERROR;
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                S_ERROR: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench: DRP slave and MMCM lock models, an arithmetic model of the
// expected access stream, and one per-cycle compare process on the DRP bus.
module tb_mmcm_drp_reconfig;
    localparam int DRDY_TO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] clkfb_mult = 8'd0, clkout0_div = 8'd0, divclk_div = 8'd0;
    logic       busy, done, error, mmcm_rst;
    logic       mmcm_locked;

    mmcm_drp_reconfig_if drp();

    mmcm_drp_reconfig #(.DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(200)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .clkfb_mult(clkfb_mult), .clkout0_div(clkout0_div), .divclk_div(divclk_div),
        .busy(busy), .done(done), .error(error), .mmcm_rst(mmcm_rst),
        .mmcm_locked(mmcm_locked), .drp(drp)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // DRP slave: drdy three edges after the strobe, optionally withheld for one access
    int          acc_cnt = 0, pend = 0, withhold_at = 0;
    logic [15:0] rd_fill = 16'hFFFF;
    always @(posedge clk) begin
        drp.drp_drdy <= 1'b0;
        if (drp.drp_den === 1'b1) begin
            acc_cnt <= acc_cnt + 1;
            pend    <= (acc_cnt + 1 == withhold_at) ? 0 : 2;
        end else if (pend == 1) begin
            drp.drp_drdy <= 1'b1;
            drp.drp_do   <= rd_fill;
            pend         <= 0;
        end else if (pend > 1) begin
            pend <= pend - 1;
        end
    end

    // MMCM lock: drops while in reset, returns five cycles after release
    int lk = 0;
    always @(posedge clk) begin
        if (mmcm_rst === 1'b1) begin
            lk          <= 0;
            mmcm_locked <= 1'b0;
        end else if (lk < 5) begin
            lk <= lk + 1;
        end else begin
            mmcm_locked <= 1'b1;
        end
    end

    // Expected access stream
    int          addr_t[5] = '{8, 9, 20, 21, 22};
    int          mask_t[5] = '{32'h1000, 32'hFC00, 32'h1000, 32'hFC00, 32'hC000};
    logic [6:0]  e_addr[0:127];
    logic        e_we[0:127];
    logic [15:0] e_data[0:127];
    logic [15:0] wr_log[0:127];
    int          exp_total = 0, seen = 0;
    logic        prev_den = 1'b0;

    function automatic int hilo(input int v);
        int half, hi, lo;
        half = v / 2;
        hi   = (half == 0) ? 1 : half;
        lo   = (half + v % 2) % 64;
        return hi * 64 + lo;
    endfunction

    function automatic int edge_nc(input int v);
        return (((v / 2) == 0) ? 0 : (v % 2)) * 128 + ((v == 1) ? 64 : 0);
    endfunction

    task automatic push_expect(input int m, input int d0, input int dc,
                               input logic [15:0] fill, input int n_acc);
        int f;
        for (int i = 0; i < n_acc; i++) begin
            case (i / 2)
                0:       f = hilo(d0);
                1:       f = edge_nc(d0);
                2:       f = hilo(m);
                3:       f = edge_nc(m);
                default: f = edge_nc(dc) * 64 + hilo(dc);
            endcase
            e_addr[exp_total] = 7'(addr_t[i / 2]);
            e_we[exp_total]   = (i % 2 == 1);
            e_data[exp_total] = 16'((int'(fill) & mask_t[i / 2]) | f);
            exp_total++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (drp.drp_den === 1'b1) begin
                chk("den_spacing", 32'(prev_den), 32'd0);
                chk("rst_held_during_drp", 32'(mmcm_rst), 32'd1);
                if (seen >= exp_total) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_den: addr 0x%0h, expected no access", drp.drp_daddr);
                end else begin
                    chk("drp_addr", 32'(drp.drp_daddr), 32'(e_addr[seen]));
                    chk("drp_we", 32'(drp.drp_dwe), 32'(e_we[seen]));
                    if (e_we[seen]) chk("drp_wdata", 32'(drp.drp_di), 32'(e_data[seen]));
                end
                if (drp.drp_dwe === 1'b1) wr_log[drp.drp_daddr] = drp.drp_di;
                seen++;
            end
            prev_den = (drp.drp_den === 1'b1);
        end
    end

    task automatic launch(input int m, input int d0, input int dc,
                          input logic [15:0] fill, input int n_acc);
        @(negedge clk);
        rd_fill = fill;
        push_expect(m, d0, dc, fill, n_acc);
        clkfb_mult  = 8'(m);
        clkout0_div = 8'(d0);
        divclk_div  = 8'(dc);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, output bit got_done, output bit got_err);
        int i;
        got_done = 0;
        got_err  = 0;
        i = 0;
        while (!got_done && !got_err && i < 400) begin
            @(negedge clk);
            i++;
            if (done === 1'b1) got_done = 1;
            else if (error === 1'b1) got_err = 1;
        end
        if (!got_done && !got_err) chk({name, "_end_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_seen(input int target, input string name);
        int i;
        i = 0;
        while (seen < target && i < 300) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (seen < target) chk({name, "_drp_timeout"}, 32'(seen), 32'(target));
    endtask

    task automatic run_ok(input string name, input int m, input int d0, input int dc,
                          input logic [15:0] fill);
        bit gd, ge;
        int base;
        base = exp_total;
        launch(m, d0, dc, fill, 10);
        chk({name, "_busy"}, 32'(busy), 32'd1);
        chk({name, "_error_cleared"}, 32'(error), 32'd0);
        wait_end(name, gd, ge);
        chk({name, "_done"}, 32'(gd), 32'd1);
        chk({name, "_locked_at_done"}, 32'(mmcm_locked), 32'd1);
        chk({name, "_rst_released"}, 32'(mmcm_rst), 32'd0);
        chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
        chk({name, "_strobes"}, 32'(seen - base), 32'd10);
    endtask

    task automatic run_bad(input string name, input int m, input int d0, input int dc);
        bit ge, rst_seen;
        int base;
        base = exp_total;
        launch(m, d0, dc, 16'hFFFF, 0);
        ge = 0;
        rst_seen = (mmcm_rst === 1'b1);
        for (int i = 0; i < 2 && !ge; i++) begin
            @(negedge clk);
            if (mmcm_rst === 1'b1) rst_seen = 1;
            if (error === 1'b1) ge = 1;
        end
        chk({name, "_error"}, 32'(ge), 32'd1);
        @(negedge clk);
        if (mmcm_rst === 1'b1) rst_seen = 1;
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_error_held"}, 32'(error), 32'd1);
        chk({name, "_no_rst"}, 32'(rst_seen), 32'd0);
        chk({name, "_no_den"}, 32'(seen), 32'(base));
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_error"}, 32'(error), 32'd0);
        chk({name, "_mmcm_rst"}, 32'(mmcm_rst), 32'd0);
        chk({name, "_den"}, 32'(drp.drp_den), 32'd0);
        chk({name, "_dwe"}, 32'(drp.drp_dwe), 32'd0);
        chk({name, "_daddr"}, 32'(drp.drp_daddr), 32'd0);
        chk({name, "_di"}, 32'(drp.drp_di), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gd, ge;
        int base, n;

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 5/10/1 against all-ones and all-zeros read data
        run_ok("A", 10, 5, 1, 16'hFFFF);
        chk("A_r08", 32'(wr_log[8'h08]), 32'h1083);
        chk("A_r09", 32'(wr_log[8'h09]), 32'hFC80);
        chk("A_r14", 32'(wr_log[8'h14]), 32'h1145);
        chk("A_r15", 32'(wr_log[8'h15]), 32'hFC00);
        chk("A_r16", 32'(wr_log[8'h16]), 32'hD041);

        run_ok("B", 10, 5, 1, 16'h0000);
        chk("B_r08", 32'(wr_log[8'h08]), 32'h0083);
        chk("B_r09", 32'(wr_log[8'h09]), 32'h0080);
        chk("B_r14", 32'(wr_log[8'h14]), 32'h0145);
        chk("B_r15", 32'(wr_log[8'h15]), 32'h0000);
        chk("B_r16", 32'(wr_log[8'h16]), 32'h1041);

        // out-of-range inputs
        run_bad("C_mult0", 0, 5, 1);
        run_bad("D_div128", 10, 128, 1);

        // third access never answered
        base = exp_total;
        withhold_at = acc_cnt + 3;
        launch(10, 5, 1, 16'hFFFF, 3);
        wait_seen(base + 3, "E");
        n = 0;
        while (error !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("E_timeout_window", 32'(n >= DRDY_TO && n <= DRDY_TO + 2), 32'd1);
        chk("E_mmcm_rst", 32'(mmcm_rst), 32'd0);
        chk("E_busy", 32'(busy), 32'd0);
        chk("E_no_more_den", 32'(seen), 32'(base + 3));
        withhold_at = 0;

        run_ok("F", 36, 7, 2, 16'hA5A5);

        // start pulsed in WAIT_RD with junk inputs must be ignored
        base = exp_total;
        launch(20, 3, 4, 16'h0F0F, 10);
        wait_seen(base + 1, "G");
        @(negedge clk);
        clkfb_mult = 8'd0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("G", gd, ge);
        chk("G_done", 32'(gd), 32'd1);
        chk("G_error", 32'(error), 32'd0);
        repeat (4) @(negedge clk);
        chk("G_strobes", 32'(seen - base), 32'd10);

        // reset asserted in WAIT_WR
        base = exp_total;
        launch(10, 5, 1, 16'hFFFF, 10);
        wait_seen(base + 2, "H");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("H_async_rst");
        exp_total = seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_ok("H_after", 10, 5, 1, 16'h0000);
        chk("H_r08", 32'(wr_log[8'h08]), 32'h0083);
        chk("H_r16", 32'(wr_log[8'h16]), 32'h1041);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
